// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive-only target.
// Holds the target FSM state encoding and byte/address defaults.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_DATA   = 3'd3,
        ST_ACK_D  = 3'd4,
        ST_IGNORE = 3'd5
    } slave_state_t;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;
    localparam int         BITS_PER_BYTE    = 8;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// I2C bus bundle between an upstream master and the receive-only target.
// Ports: i2c_scl, i2c_sda (master -> target), sda_oe (target pull-down request).
interface i2c_slave_rx_if;

    logic i2c_scl;
    logic i2c_sda;
    logic sda_oe;

    modport master (
        output i2c_scl,
        output i2c_sda,
        input  sda_oe
    );

    modport slave (
        input  i2c_scl,
        input  i2c_sda,
        output sda_oe
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and derives bus events.
// Ports: clk, reset (sync, active-low), scl_in/sda_in -> sda, scl_rise, scl_fall, start_det, stop_det.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_q;
    logic [SYNC_STAGES-1:0] sda_q;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Reset to 1 so the bus looks idle and no false edge follows reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_in};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_in};
            scl_d <= scl_q[SYNC_STAGES-1];
            sda_d <= sda_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_q[SYNC_STAGES-1];
    assign sda       = sda_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // Qualified by the current synchronized SCL, so SCL and SDA leaving
    // their reset value together can never look like START/STOP.
    assign start_det = scl_s & sda_d & ~sda;
    assign stop_det  = scl_s & ~sda_d & sda;

endmodule

// File: rtl/i2c_slave_rx.sv
// Receive-only I2C target: decodes address, collects data bytes, ACKs on match.
// Ports: clk, reset (sync, active-low), bus (i2c_scl, i2c_sda, sda_oe), rx_addr,
// rx_rw, rx_data, rx_valid, addr_match, busy, stop_seen.
// Macro I2C_SLAVE_ACK_EN: drive ACKs; when undefined sda_oe is tied 0 (monitor).
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    i2c_slave_rx_if.slave      bus,
    output logic [6:0]         rx_addr,
    output logic               rx_rw,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic               addr_match,
    output logic               busy,
    output logic               stop_seen
);

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    logic         sda;
    logic         scl_rise;
    logic         scl_fall;
    logic         start_det;
    logic         stop_det;

    slave_state_t state;
    slave_state_t state_n;
    logic [2:0]   bit_cnt;
    logic [2:0]   bit_cnt_n;
    logic [7:0]   shreg;
    logic [7:0]   shreg_n;
    logic [7:0]   byte_in;
    logic [6:0]   rx_addr_n;
    logic         rx_rw_n;
    logic [7:0]   rx_data_n;
    logic         rx_valid_n;
    logic         addr_match_n;
    logic         busy_n;
    logic         stop_seen_n;
    // High while the ACK slot is being driven (first fall to second fall).
    logic         ack_drv;
    logic         ack_drv_n;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (bus.i2c_scl),
        .sda_in    (bus.i2c_sda),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in = {shreg[6:0], sda};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_addr    <= '0;
            rx_rw      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            stop_seen  <= 1'b0;
            ack_drv    <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            rx_addr    <= rx_addr_n;
            rx_rw      <= rx_rw_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            addr_match <= addr_match_n;
            busy       <= busy_n;
            stop_seen  <= stop_seen_n;
            ack_drv    <= ack_drv_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        rx_addr_n    = rx_addr;
        rx_rw_n      = rx_rw;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        addr_match_n = addr_match;
        busy_n       = busy;
        stop_seen_n  = 1'b0;
        ack_drv_n    = ack_drv;

        if (stop_det) begin
            state_n      = ST_IDLE;
            busy_n       = 1'b0;
            addr_match_n = 1'b0;
            ack_drv_n    = 1'b0;
            stop_seen_n  = 1'b1;
        end else if (start_det) begin
            // START wins over a coincident SCL rise.
            state_n      = ST_ADDR;
            bit_cnt_n    = '0;
            busy_n       = 1'b1;
            addr_match_n = 1'b0;
            ack_drv_n    = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            if (state == ST_ADDR) begin
                                rx_addr_n = byte_in[7:1];
                                rx_rw_n   = byte_in[0];
                                state_n   = ST_ACK_A;
                            end else begin
                                rx_data_n  = byte_in;
                                rx_valid_n = 1'b1;
                                state_n    = ST_ACK_D;
                            end
                        end
                    end
                end
                ST_ACK_A, ST_ACK_D: begin
                    if (state == ST_ACK_A && rx_addr != SLAVE_ADDR) begin
                        state_n = ST_IGNORE;
                    end else begin
                        addr_match_n = 1'b1;
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv_n = 1'b1;
                            end else begin
                                ack_drv_n = 1'b0;
                                bit_cnt_n = '0;
                                state_n   = ST_DATA;
                            end
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

`ifdef I2C_SLAVE_ACK_EN
    assign bus.sda_oe = ack_drv;
`else
    assign bus.sda_oe = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: bit-banged master, vector table,
// and a scoreboard queue of expected rx_data bytes.
module tb_i2c_slave_rx;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [6:0] rx_addr;
    logic       rx_rw;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;
    logic       stop_seen;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int stop_cnt = 0;
    int oe_cnt = 0;

    logic [7:0] exp_q[$];

    i2c_slave_rx_if bus ();

    assign bus.i2c_scl = m_scl;
    assign bus.i2c_sda = m_sda & ~bus.sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .rx_addr    (rx_addr),
        .rx_rw      (rx_rw),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .busy       (busy),
        .stop_seen  (stop_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        int         nbits;
        logic       exp_match;
        int         exp_valid;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer and event counters.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h expected none",
                             rx_data);
                end else begin
                    chk("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (stop_seen) stop_cnt++;
            if (bus.sda_oe) oe_cnt++;
        end
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        w(HALF / 2);
        m_scl = 1'b1;
        w(HALF);
        m_scl = 1'b0;
        w(HALF / 2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        w(HALF / 2);
        m_scl = 1'b1;
        w(HALF);
        m_sda = 1'b0;
        w(HALF);
        m_scl = 1'b0;
        w(HALF / 2);
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        w(HALF / 2);
        m_scl = 1'b1;
        w(HALF);
        m_sda = 1'b1;
        w(HALF + 4);
    endtask

    function automatic int exp_oe(input int nacks);
`ifdef I2C_SLAVE_ACK_EN
        return nacks * 2 * HALF;
`else
        return 0 * nacks;
`endif
    endfunction

    initial begin
        int v0, s0, o0, nacks;

        vecs[0] = '{7'h50, 1'b1, 8'hA5, 8, 1'b1, 1};
        vecs[1] = '{7'h51, 1'b0, 8'h3C, 8, 1'b0, 0};
        vecs[2] = '{7'h50, 1'b0, 8'h5A, 4, 1'b1, 0};
        vecs[3] = '{7'h50, 1'b1, 8'hFF, 8, 1'b1, 1};
        vecs[4] = '{7'h50, 1'b0, 8'h00, 8, 1'b1, 1};
        vecs[5] = '{7'h28, 1'b1, 8'h81, 8, 1'b0, 0};

        // Reset state
        w(5);
        chk("rst_rx_addr", {25'd0, rx_addr}, 0);
        chk("rst_rx_rw", {31'd0, rx_rw}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_addr_match", {31'd0, addr_match}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_stop_seen", {31'd0, stop_seen}, 0);
        chk("rst_sda_oe", {31'd0, bus.sda_oe}, 0);
        reset = 1'b1;
        w(5);

        // Table of complete / truncated transfers
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            s0 = stop_cnt;
            o0 = oe_cnt;
            do_start();
            chk($sformatf("v%0d_busy_start", i), {31'd0, busy}, 1);
            send_byte({vecs[i].addr, vecs[i].rw});
            send_bit(1'b1);
            chk($sformatf("v%0d_rx_addr", i), {25'd0, rx_addr},
                {25'd0, vecs[i].addr});
            chk($sformatf("v%0d_rx_rw", i), {31'd0, rx_rw},
                {31'd0, vecs[i].rw});
            chk($sformatf("v%0d_addr_match", i), {31'd0, addr_match},
                {31'd0, vecs[i].exp_match});
            if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
            for (int b = 7; b >= 8 - vecs[i].nbits; b--)
                send_bit(vecs[i].data[b]);
            if (vecs[i].nbits == 8) send_bit(1'b1);
            do_stop();
            nacks = vecs[i].exp_match ? (vecs[i].nbits == 8 ? 2 : 1) : 0;
            chk($sformatf("v%0d_busy_stop", i), {31'd0, busy}, 0);
            chk($sformatf("v%0d_match_stop", i), {31'd0, addr_match}, 0);
            chk($sformatf("v%0d_stop_cnt", i), s0 + 1, stop_cnt);
            chk($sformatf("v%0d_valid_cnt", i), valid_cnt - v0,
                vecs[i].exp_valid);
            chk($sformatf("v%0d_oe_cycles", i), oe_cnt - o0, exp_oe(nacks));
            w(4);
        end

        // Repeated START mid-data, then a fresh matching transfer
        v0 = valid_cnt;
        o0 = oe_cnt;
        do_start();
        send_byte({7'h50, 1'b0});
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        do_start();
        chk("rs_match_clr", {31'd0, addr_match}, 0);
        chk("rs_busy", {31'd0, busy}, 1);
        send_byte({7'h50, 1'b0});
        send_bit(1'b1);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F);
        send_bit(1'b1);
        do_stop();
        chk("rs_valid_cnt", valid_cnt - v0, 1);
        chk("rs_rx_data", {24'd0, rx_data}, 32'h0F);
        chk("rs_oe_cycles", oe_cnt - o0, exp_oe(3));
        w(4);

        // Reset pulse during DATA, trailing bits must be ignored
        v0 = valid_cnt;
        o0 = oe_cnt;
        do_start();
        send_byte({7'h50, 1'b1});
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b0;
        w(1);
        reset = 1'b1;
        chk("mr_rx_addr", {25'd0, rx_addr}, 0);
        chk("mr_rx_rw", {31'd0, rx_rw}, 0);
        chk("mr_rx_data", {24'd0, rx_data}, 0);
        chk("mr_addr_match", {31'd0, addr_match}, 0);
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_sda_oe", {31'd0, bus.sda_oe}, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("mr_tail_busy", {31'd0, busy}, 0);
        chk("mr_tail_match", {31'd0, addr_match}, 0);
        do_stop();
        chk("mr_valid_cnt", valid_cnt - v0, 0);
        chk("mr_oe_cycles", oe_cnt - o0, 0);
        w(4);

        // Recovery after reset
        v0 = valid_cnt;
        do_start();
        send_byte({7'h50, 1'b0});
        send_bit(1'b1);
        chk("rec_match", {31'd0, addr_match}, 1);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3);
        send_bit(1'b1);
        do_stop();
        chk("rec_valid_cnt", valid_cnt - v0, 1);
        chk("rec_rx_data", {24'd0, rx_data}, 32'hC3);

        w(4);
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter: SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
REQ-002 Parameter: SYNC_STAGES, 2, number of synchronizer flops on i2c_scl and i2c_sda (minimum 2).
REQ-003 Port: clk  input  1  system clock; single clock domain; all sequential logic on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-low reset (asserted when 0), sampled on posedge clk.
REQ-005 Port: i2c_scl  input  1  bus clock from the upstream i2c_master; asynchronous to clk.
REQ-006 Port: i2c_sda  input  1  bus data from the upstream i2c_master; asynchronous to clk.
REQ-007 Port: sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-008 Port: rx_addr  output  7  address of the last completed address phase.
REQ-009 Port: rx_rw  output  1  R/W bit of the last completed address phase.
REQ-010 Port: rx_data  output  8  last received data byte, MSB first on the wire.
REQ-011 Port: rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-012 Port: addr_match  output  1  high from the matching address phase until STOP/START.
REQ-013 Port: busy  output  1  high from START detect until STOP detect.
REQ-014 Port: stop_seen  output  1  one-clk pulse on STOP detect.

Function
REQ-015 The block shall synchronize i2c_scl and i2c_sda through SYNC_STAGES flops, then detect edges with one further flop; event latency = SYNC_STAGES+1 clk after the pin transition.
REQ-016 Each SCL high and low phase shall last >= 4 clk; behaviour for shorter phases is undefined.
REQ-017 The block shall detect START as a synchronized SDA fall while synchronized SCL = 1, and STOP as a synchronized SDA rise while SCL = 1.
REQ-018 Data bits shall be sampled on the synchronized SCL rising edge only; SDA changes while SCL = 0 shall be ignored.
REQ-019 FSM states: IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE.
REQ-020 IDLE -> ADDR on START; a 3-bit bit counter shall be cleared and busy set.
REQ-021 ADDR shall shift in 8 bits (7 address bits MSB first, then R/W) and, on the 8th SCL rise, load rx_addr/rx_rw and go to ACK_A.
REQ-022 ACK_A: if rx_addr == SLAVE_ADDR, set addr_match, raise sda_oe on the next SCL fall, release it on the following SCL fall, then go to DATA; otherwise go to IGNORE with sda_oe = 0.
REQ-023 DATA shall shift in 8 bits; on the 8th SCL rise, load rx_data and pulse rx_valid on the same clk edge that loads it; then go to ACK_D.
REQ-024 ACK_D shall drive the ACK as in ACK_A, then return to DATA for the next byte; any number of bytes is accepted.
REQ-025 The R/W bit shall be reported only; the block shall treat every post-address byte as received data.
REQ-026 IGNORE shall hold sda_oe = 0 and leave only on START or STOP.
REQ-027 STOP in any state shall go to IDLE, pulse stop_seen, and clear busy, addr_match and sda_oe; a partial byte is discarded and rx_valid does not pulse.
REQ-028 START in any non-IDLE state (repeated start) shall go to ADDR, clear the bit counter and addr_match, and release sda_oe.
REQ-029 START and STOP in the same clk are impossible by construction; when START coincides with an SCL rise, START shall take priority.

Reset
REQ-030 While reset = 0: state = IDLE, sda_oe = 0, rx_addr = 0, rx_rw = 0, rx_data = 0, rx_valid = 0, addr_match = 0, busy = 0, stop_seen = 0, and synchronizer flops = 1 (bus idle).
REQ-031 Reset asserted mid-transfer shall abort the transfer; after release the block shall wait for a fresh START.

Configuration
REQ-032 Macro I2C_SLAVE_ACK_EN: when defined, ACK driving shall behave per REQ-022/REQ-024.
REQ-033 When I2C_SLAVE_ACK_EN is undefined, sda_oe shall be constant 0 and the block shall act as a passive monitor; all other outputs and the state flow are unchanged.

Structure
REQ-034 Package i2c_pkg shall hold the slave state enum (3 bits), the default address constant 7'h50, and the bit-count constant 8.
REQ-035 Sub-module i2c_line_sync shall perform the synchronization and edge detection and provide scl_rise, scl_fall, start_det and stop_det; i2c_slave_rx shall instantiate it once.

Verification
REQ-036 i2c_master sends addr 7'h50, data 8'hA5 -> addr_match = 1, rx_addr = 7'h50, rx_rw = 1, one rx_valid with rx_data = 8'hA5, stop_seen pulses once.
REQ-037 Address 7'h51, data 8'h3C -> addr_match = 0, sda_oe never 1, rx_valid never pulses, busy falls on STOP.
REQ-038 Match with ACK_EN defined -> sda_oe high for exactly one SCL low+high period after the 8th address bit and after the 8th data bit; with ACK_EN undefined -> sda_oe = 0 throughout.
REQ-039 STOP injected after 4 data bits -> no rx_valid, state = IDLE, busy = 0.
REQ-040 Repeated START mid-data, then addr 7'h50 with data 8'h0F -> rx_valid once, with rx_data = 8'h0F.
REQ-041 reset = 0 for 1 clk during the DATA phase -> all outputs 0 the next clk; the trailing bus bits are ignored until a new START.
